// File: rtl/acc_result_collector.sv
// Keeps only the last beat of each accumulation group from the accumulator result
// stream. Results queue in a small FIFO that drains through a valid/ready handshake.
// A result that arrives while the FIFO is full is dropped, and a sticky overflow flag records it.
// Optional macro COLLECT_TAG_EN adds an outTag port carrying each result's capture index.
module acc_result_collector #(
    parameter int dataWidth = 32,
    parameter int pvadd     = 128,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         accValid,
    input  logic                         accLast,
    input  logic [dataWidth*pvadd-1:0]   accVector,
    output logic                         outValid,
    input  logic                         outReady,
    output logic [dataWidth*pvadd-1:0]   outVector,
    output logic [$clog2(DEPTH):0]       fifoLevel,
    output logic [CNT_W-1:0]             resultCount,
`ifdef COLLECT_TAG_EN
    output logic [CNT_W-1:0]             outTag,
`endif
    output logic                         overflow
);

    localparam int VW = dataWidth * pvadd;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [VW-1:0]    mem [DEPTH];

    logic push, pop, full, accept, drop;

    always_comb begin
        push   = accValid & accLast;
        pop    = (level_q != '0) & outReady;
        full   = (level_q == LW'(DEPTH));
        // At full, a pop in the same cycle frees the slot that the push reuses.
        accept = push & (~full | pop);
        drop   = push & full & ~pop;

        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            count_d  = count_q + CNT_W'(1);
        end
        if (accept && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !accept) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; outputs are gated by level instead.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= accVector;
        end
    end

    always_comb begin
        outValid    = (level_q != '0);
        outVector   = (level_q != '0) ? mem[rd_ptr_q] : '0;
        fifoLevel   = level_q;
        resultCount = count_q;
        overflow    = overflow_q;
    end

`ifdef COLLECT_TAG_EN
    logic [CNT_W-1:0] tag_mem [DEPTH];

    // The pre-increment count becomes the tag, so the first result after reset is tag 0.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr_q] <= count_q;
        end
    end

    always_comb begin
        outTag = (level_q != '0) ? tag_mem[rd_ptr_q] : '0;
    end
`endif

endmodule

// File: doc/acc_result_collector.md
Name: acc_result_collector

Overview:
- Receive-side companion to the per-lane floating-point accumulator array.
- Watches the accumulator's result stream (valid, last, vector) and keeps only the final vector of each accumulation group, the beat with last=1. Intermediate partial sums are discarded.
- Buffers captured results in a small FIFO and presents them to downstream logic (aggregation writeback) through a valid/ready handshake.
- The accumulator has no backpressure, so this block is the point where overflow is detected and flagged.

Parameters:
dataWidth, 32, width of one lane element (fp32)
pvadd, 128, number of lanes per vector
DEPTH, 4, result FIFO entries; power of two, >= 2
CNT_W, 16, width of result counter

Ports:
clk  in  1  clock
rst  in  1  reset
accValid  in  1  result-valid from accumulator array
accLast  in  1  result-last from accumulator array (end of accumulation group)
accVector  in  dataWidth*pvadd  accumulated vector, lane i at bits [(i+1)*dataWidth-1 : i*dataWidth]
outValid  out  1  FIFO head holds a result
outReady  in  1  downstream accepts head this cycle
outVector  out  dataWidth*pvadd  FIFO head vector
fifoLevel  out  clog2(DEPTH)+1  entries currently stored
resultCount  out  CNT_W  results captured since reset
overflow  out  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high (clk, rst).
  - Reset clears rdPtr, wrPtr, fifoLevel, resultCount and overflow to 0.
  - outValid=0; outVector=0. FIFO memory is not reset.
- Capture condition: push = accValid & accLast. Beats with accValid=1, accLast=0 are ignored. accLast with accValid=0 is ignored.
- Pop condition: pop = outValid & outReady.
- Accepted push:
  - Condition: level < DEPTH, or level==DEPTH with pop in the same cycle.
  - Writes mem[wrPtr], wrPtr+1 mod DEPTH, resultCount+1 (wraps at 2^CNT_W).
- Dropped push:
  - Condition: level==DEPTH and no pop.
  - Vector discarded; overflow set to 1 and held until rst.
  - resultCount unchanged; state otherwise unchanged.
- Pop: rdPtr+1 mod DEPTH.
- Level update each cycle: level += accepted_push - pop. Push and pop in the same cycle leave level unchanged.
- Empty FIFO + push + outReady=1: no pop that cycle, because outValid was 0.
- Outputs:
  - outValid = (level != 0).
  - outVector = mem[rdPtr] when level != 0, else all zeros.
  - Both are driven from registered state; no combinational path from accVector or outReady to outputs.
- Latency: a result captured at clock edge k is visible on outValid/outVector after edge k, i.e. one cycle, when the FIFO was empty.
- Ordering: strict FIFO. Results leave in capture order.
- Holding rule: while outValid=1 and outReady=0, outVector and outValid stay stable.
- Reset mid-operation: all buffered results are lost and outputs return to reset values immediately (asynchronous). No partial pop is visible.

Optional Feature:
- Macro: COLLECT_TAG_EN.
- Defined:
  - Adds port outTag (out, CNT_W), a per-entry tag FIFO in parallel with the data FIFO.
  - On an accepted push, the tag written is the pre-increment resultCount value, so the first result after reset has tag 0.
  - outTag = tag of the head entry when level != 0, else 0. Reset value 0.
  - Dropped pushes consume no tag.
- Undefined: no outTag port, no tag storage; all other behaviour identical.

Test Plan:
- Group filtering: three beats with accValid=1, accLast=0,0,1 and vectors lane0=1.0,2.0,3.0 (0x3F800000, 0x40000000, 0x40400000); outReady=1 -> exactly one outValid pulse, outVector lane0=0x40400000, resultCount=1.
- Fill to full: 4 last-beats (vectors A..D), outReady=0 -> fifoLevel=4, outVector=A, overflow=0. A 5th last-beat E -> overflow=1, fifoLevel=4, resultCount=4. Then drain with outReady=1 -> A,B,C,D in order, outValid=0 afterward.
- Full with simultaneous push/pop: level=4, push F with outReady=1 -> F accepted, level stays 4, overflow unchanged, F emerges fourth.
- Backpressure stability: level=2, outReady toggles 0,0,1 -> outVector/outValid unchanged during the two stalled cycles; head advances only on the third.
- Async reset mid-operation: level=3, assert rst between clock edges -> outValid=0, outVector=0, fifoLevel=0, resultCount=0, overflow=0 immediately. The first push after deassertion is output one cycle later.
- (COLLECT_TAG_EN) Five group-ends with one drop at full -> tags on output are 0,1,2,3 in order, then tag 4 for the next accepted push after a pop.
